// File: rtl/encoder_16_to_4_seq.sv
// Registered 16-to-4 priority encoder with sticky request capture and valid/ack handoff.
// Latency: req sampled at edge k sets pending at edge k; code/valid follow at edge k+1.
// Backpressure: a presented code is held (no preemption) until ack; requests keep accumulating in pending.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous reset, active-low (clears pending, code, valid)
//   E        capture enable for req (0 = new requests ignored)
//   req      N request lines, level-sampled every edge, sticky in pending
//   ack      consumer accepts the current code (ignored while valid=0)
//   mask     N-bit selection mask, present only when ENC_MASK_EN is defined
//   code     highest eligible pending index, registered
//   valid    code is valid, registered
//   pending  sticky pending register
//
// Build option ENC_MASK_EN: adds the mask port. Masked bits still latch into
// pending but are never selected; a code already presented stays until ack.
module encoder_16_to_4_seq #(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                E,
  input  logic [(1<<W)-1:0]   req,
  input  logic                ack,
`ifdef ENC_MASK_EN
  input  logic [(1<<W)-1:0]   mask,
`endif
  output logic [W-1:0]        code,
  output logic                valid,
  output logic [(1<<W)-1:0]   pending
);

  localparam int N = 1 << W;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_code;
  logic           r_valid;
  logic [N-1:0]   r_pending;

  logic [N-1:0]   w_clr;
  logic [N-1:0]   w_cap;
  logic [N-1:0]   w_pend_nxt;
  logic [N-1:0]   w_elig_cur;
  logic [N-1:0]   w_elig_nxt;
  logic [W-1:0]   w_sel_cur;
  logic [W-1:0]   w_sel_nxt;

  // Highest set index wins; returns 0 for an all-zero vector (callers gate on |v).
  function automatic logic [W-1:0] f_prio(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  // Clear only the bit being handed off; a same-edge capture re-sets it.
  assign w_clr      = (r_valid && ack) ? ({{(N-1){1'b0}}, 1'b1} << r_code) : '0;
  assign w_cap      = E ? req : '0;
  assign w_pend_nxt = (r_pending & ~w_clr) | w_cap;

`ifdef ENC_MASK_EN
  assign w_elig_cur = r_pending  & ~mask;
  assign w_elig_nxt = w_pend_nxt & ~mask;
`else
  assign w_elig_cur = r_pending;
  assign w_elig_nxt = w_pend_nxt;
`endif

  assign w_sel_cur = f_prio(w_elig_cur);
  assign w_sel_nxt = f_prio(w_elig_nxt);

  // From IDLE the decision uses the registered pending, so a fresh request
  // is visible on code/valid one edge after it is captured. On an ack the
  // post-clear, post-capture view is used so back-to-back handoff keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      case (r_state)
        S_IDLE: begin
          if (|w_elig_cur) begin
            r_state <= S_PRESENT;
            r_code  <= w_sel_cur;
            r_valid <= 1'b1;
          end
        end
        S_PRESENT: begin
          if (ack) begin
            if (|w_elig_nxt) begin
              r_code <= w_sel_nxt;
            end else begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign code    = r_code;
  assign valid   = r_valid;
  assign pending = r_pending;

endmodule

// File: tb/tb_encoder_16_to_4_seq.sv
module tb_encoder_16_to_4_seq;

  logic        clk;
  logic        rst_n;
  logic        E;
  logic [15:0] req;
  logic        ack;
  logic [15:0] mask;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] pending;

  encoder_16_to_4_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .E       (E),
    .req     (req),
    .ack     (ack),
`ifdef ENC_MASK_EN
    .mask    (mask),
`endif
    .code    (code),
    .valid   (valid),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  c;
    logic [15:0] p;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a set of outstanding request indices plus "what is
  // being offered to the consumer right now".
  bit   m_pend [16];
  bit   m_valid;
  int   m_code;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int highest(input bit v [16], input logic [15:0] m);
    for (int i = 15; i >= 0; i--) if (v[i] && !m[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] pend_vec();
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = m_pend[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0;
    m_code  = 0;
  endtask

  task automatic model_edge(input logic e, input logic [15:0] r, input logic a, input logic [15:0] m);
    bit nxt [16];
    int h_cur, h_nxt;
    for (int i = 0; i < 16; i++)
      nxt[i] = (m_pend[i] && !(m_valid && a && m_code == i)) || (e && r[i]);
    h_cur = highest(m_pend, m);
    h_nxt = highest(nxt, m);
    if (!m_valid) begin
      if (h_cur >= 0) begin
        m_valid = 1'b1;
        m_code  = h_cur;
      end
    end else if (a) begin
      if (h_nxt >= 0) m_code = h_nxt;
      else            m_valid = 1'b0;
    end
    for (int i = 0; i < 16; i++) m_pend[i] = nxt[i];
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic step(input logic e, input logic [15:0] r, input logic a, input logic [15:0] m);
    exp_t x;
    @(negedge clk);
    E = e; req = r; ack = a; mask = m;
    model_edge(e, r, a, m);
    x.v = m_valid; x.c = 4'(m_code); x.p = pend_vec();
    q.push_back(x);
    @(posedge clk);
  endtask

  // Monitor: compares every presented output against the queued expectation.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (rst_n && q.size() > 0) begin
      x = q.pop_front();
      check("sb_valid",   int'(valid),   int'(x.v));
      check("sb_pending", int'(pending), int'(x.p));
      if (x.v) check("sb_code", int'(code), int'(x.c));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; E = 1'b0; req = '0; ack = 1'b0; mask = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] r;
    logic [15:0] m;
    rst_n = 1'b0; E = 1'b0; req = '0; ack = 1'b0; mask = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_code",    int'(code),    0);
    check("reset_valid",   int'(valid),   0);
    check("reset_pending", int'(pending), 0);
    rst_n = 1'b1;

    // Single request, one-cycle latency to valid, then handoff
    step(1, 16'h0001, 0, '0);
    #1 check("t2_pend1", int'(pending), 16'h0001);
    check("t2_valid_not_yet", int'(valid), 0);
    step(0, 16'h0000, 0, '0);
    #1 check("t2_valid", int'(valid), 1);
    check("t2_code", int'(code), 0);
    step(0, 16'h0000, 1, '0);
    #1 check("t2_ack_valid", int'(valid), 0);
    check("t2_ack_pend", int'(pending), 0);

    // Back-to-back handoff with ack held high
    step(1, 16'h8421, 1, '0);
    step(0, 16'h0000, 1, '0);
    #1 check("t3_code15", int'(code), 15);
    step(0, 16'h0000, 1, '0);
    #1 check("t3_code10", int'(code), 10);
    check("t3_valid", int'(valid), 1);
    step(0, 16'h0000, 1, '0);
    #1 check("t3_code5", int'(code), 5);
    step(0, 16'h0000, 1, '0);
    #1 check("t3_code0", int'(code), 0);
    step(0, 16'h0000, 1, '0);
    #1 check("t3_done", int'(valid), 0);

    // No preemption while holding
    step(1, 16'h0008, 0, '0);
    step(0, 16'h0000, 0, '0);
    step(1, 16'h1000, 0, '0);
    #1 check("t4_hold", int'(code), 3);
    check("t4_pend", int'(pending), 16'h1008);
    step(0, 16'h0000, 1, '0);
    #1 check("t4_next", int'(code), 12);
    step(0, 16'h0000, 1, '0);

    // Re-capture on the ack edge
    step(1, 16'h0080, 0, '0);
    step(0, 16'h0000, 0, '0);
    step(1, 16'h0080, 1, '0);
    #1 check("t5_recap_pend", int'(pending), 16'h0080);
    check("t5_recap_code", int'(code), 7);
    check("t5_recap_valid", int'(valid), 1);
    step(0, 16'h0080, 1, '0);
    #1 check("t5_nocap_pend", int'(pending), 0);
    check("t5_nocap_valid", int'(valid), 0);

`ifdef ENC_MASK_EN
    step(1, 16'h8001, 0, 16'h8000);
    step(0, 16'h0000, 0, 16'h8000);
    #1 check("t6_code0", int'(code), 0);
    step(0, 16'h0000, 1, 16'h8000);
    #1 check("t6_valid0", int'(valid), 0);
    check("t6_pend", int'(pending), 16'h8000);
    step(0, 16'h0000, 0, 16'h0000);
    #1 check("t6_code15", int'(code), 15);
    check("t6_valid1", int'(valid), 1);
    step(0, 16'h0000, 1, 16'h0000);
`endif

    // Async reset in the middle of a handoff
    step(1, 16'h0200, 0, '0);
    step(0, 16'h0000, 0, '0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid",   int'(valid),   0);
    check("arst_code",    int'(code),    0);
    check("arst_pending", int'(pending), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests: nothing ever presented
    for (int i = 0; i < 8; i++) step($urandom_range(0, 1), 16'h0000, $urandom_range(0, 1), '0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 16'h0000;
        1:       r = 16'h0001 << $urandom_range(0, 15);
        default: r = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'h0000;
      endcase
      m = '0;
`ifdef ENC_MASK_EN
      if ($urandom_range(0, 3) == 0) m = 16'($urandom);
`endif
      step($urandom_range(0, 3) != 0, r, $urandom_range(0, 1), m);
      if (i == 1500) do_reset();
    end

    repeat (2) @(negedge clk);
    check("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
